bcd_time_keeper: RTL and testbench



---
 rtl/bcd_time_keeper.sv | 158 +++++++++++++++
 tb/tb_bcd_time_keeper.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_keeper.sv
// bcd_time_keeper: 24-hour BCD clock core for a four-digit multiplexed display.
// Divides clk down to a 1 Hz tick, counts seconds/minutes/hours, and accepts
// two debounced push buttons for setting hours and minutes.
module bcd_time_keeper #(
  parameter int CLK_HZ          = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_en,
  input  logic       btn_hour,
  input  logic       btn_min,
  output logic [3:0] s_hourten,
  output logic [3:0] s_hour,
  output logic [3:0] s_minten,
  output logic [3:0] s_min,
  output logic       sec_tick,
  output logic       colon
);

  localparam int PS_W = $clog2(CLK_HZ);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_HZ - 1);
  localparam logic [PS_W-1:0] PS_HALF = PS_W'(CLK_HZ / 2 - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Minutes field {tens, units}: 00..59, wraps to 00.
  function automatic logic [7:0] min_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[7:4] = v[7:4];
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  // Hours field {tens, units}: 00..23, wraps to 00.
  function automatic logic [7:0] hour_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r[7:4] = v[7:4] + 4'd1;
      r[3:0] = 4'd0;
    end else begin
      r[7:4] = v[7:4];
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  // Bit 0 = hour button, bit 1 = minute button.
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {btn_min, btn_hour};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic            sync_p0;
    logic            sync_p1;
    logic            level;
    logic            pulse;
    logic [DB_W-1:0] cnt;

    // Synchronize the raw button, accept a new level only after it has been
    // stable for DEBOUNCE_CYCLES samples, and pulse once on an accepted press.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_p0 <= 1'b0;
        sync_p1 <= 1'b0;
        level   <= 1'b0;
        pulse   <= 1'b0;
        cnt     <= '0;
      end else begin
        sync_p0 <= btn_raw[i];
        sync_p1 <= sync_p0;
        pulse   <= 1'b0;
        if (sync_p1 != level) begin
          if (cnt == DB_LAST) begin
            level <= sync_p1;
            pulse <= sync_p1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end

    assign press[i] = pulse;
  end

  logic            press_hour;
  logic            press_min;
  logic [PS_W-1:0] presc;
  logic [5:0]      sec;
  logic [7:0]      min_bcd;
  logic [7:0]      hour_bcd;
  logic            wrap;
  logic            min_carry;
  logic            hour_carry;

  assign press_hour = press[0];
  assign press_min  = press[1];

  // A minute press restarts the second, so it suppresses the natural carry.
  assign wrap       = run_en && (presc == PS_LAST);
  assign min_carry  = wrap && (sec == 6'd59) && !press_min;
  assign hour_carry = min_carry && (min_bcd == 8'h59);

  // Prescaler, blink, seconds and the BCD minute/hour fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      sec      <= '0;
      min_bcd  <= '0;
      hour_bcd <= '0;
      sec_tick <= 1'b0;
      colon    <= 1'b0;
    end else begin
      sec_tick <= wrap;
      if (press_min) begin
        presc   <= '0;
        sec     <= '0;
        colon   <= 1'b1;
        min_bcd <= min_inc(min_bcd);
      end else begin
        if (wrap) begin
          presc <= '0;
          colon <= 1'b1;
          sec   <= (sec == 6'd59) ? 6'd0 : sec + 6'd1;
        end else if (run_en) begin
          presc <= presc + 1'b1;
          if (presc == PS_HALF) begin
            colon <= 1'b0;
          end
        end
        if (min_carry) begin
          min_bcd <= min_inc(min_bcd);
        end
      end
      if (press_hour || hour_carry) begin
        hour_bcd <= hour_inc(hour_bcd);
      end
    end
  end

  assign s_hourten = hour_bcd[7:4];
  assign s_hour    = hour_bcd[3:0];
  assign s_minten  = min_bcd[7:4];
  assign s_min     = min_bcd[3:0];

endmodule

// File: tb/tb_bcd_time_keeper.sv
// tb_bcd_time_keeper: scoreboard bench for bcd_time_keeper with a cycle model
// (minute-of-day integer arithmetic and a sample-window debouncer) plus
// scenario checks against fixed times.
module tb_bcd_time_keeper;

  localparam int CLK_HZ = 10;
  localparam int DB     = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_en;
  logic       btn_hour;
  logic       btn_min;
  logic [3:0] s_hourten;
  logic [3:0] s_hour;
  logic [3:0] s_minten;
  logic [3:0] s_min;
  logic       sec_tick;
  logic       colon;
  logic [15:0] digits;

  int checks   = 0;
  int failures = 0;
  int ticks_seen = 0;

  logic [17:0] sb_q[$];

  // Model state
  int m_ps, m_sec, m_mm, m_hh;
  bit m_tick, m_colon;
  bit m_acc[2];
  bit m_press[2];
  bit m_hist[2][0:DB];

  bcd_time_keeper #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .btn_hour(btn_hour), .btn_min(btn_min),
    .s_hourten(s_hourten), .s_hour(s_hour), .s_minten(s_minten), .s_min(s_min),
    .sec_tick(sec_tick), .colon(colon)
  );

  assign digits = {s_hourten, s_hour, s_minten, s_min};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit b[2];
    bit hp, mp, wrap, cm, ch, flip;
    b[0] = btn_hour;
    b[1] = btn_min;
    if (rst) begin
      m_ps = 0; m_sec = 0; m_mm = 0; m_hh = 0; m_tick = 0; m_colon = 0;
      for (int i = 0; i < 2; i++) begin
        m_acc[i] = 0;
        m_press[i] = 0;
        for (int j = 0; j <= DB; j++) m_hist[i][j] = 0;
      end
    end else begin
      hp   = m_press[0];
      mp   = m_press[1];
      wrap = run_en && (m_ps == CLK_HZ - 1);
      cm   = wrap && (m_sec == 59) && !mp;
      ch   = cm && (m_mm == 59);
      m_tick = wrap;
      if (mp) begin
        m_ps = 0; m_sec = 0; m_colon = 1;
        m_mm = (m_mm + 1) % 60;
      end else begin
        if (run_en) begin
          if (wrap) begin
            m_ps = 0;
            m_colon = 1;
          end else begin
            if (m_ps == CLK_HZ / 2 - 1) m_colon = 0;
            m_ps++;
          end
        end
        if (wrap) m_sec = (m_sec + 1) % 60;
        if (cm) m_mm = (m_mm + 1) % 60;
      end
      if (hp || ch) m_hh = (m_hh + 1) % 24;
      for (int i = 0; i < 2; i++) begin
        flip = 1;
        for (int j = 1; j <= DB; j++) if (m_hist[i][j] == m_acc[i]) flip = 0;
        m_press[i] = 0;
        if (flip) begin
          m_acc[i] = !m_acc[i];
          m_press[i] = m_acc[i];
        end
        for (int j = DB; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
        m_hist[i][0] = b[i];
      end
    end
    sb_q.push_back({4'(m_hh / 10), 4'(m_hh % 10), 4'(m_mm / 10), 4'(m_mm % 10), m_tick, m_colon});
  endtask

  // Model advances on every active edge and queues the expected outputs.
  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor pops one expectation per cycle and checks it away from the edge.
  initial forever begin
    logic [17:0] exp;
    bit ok;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      chk("out", 32'({digits, sec_tick, colon}), 32'(exp));
      ok = (s_hourten <= 2) && (s_hour <= 9) && (s_hourten != 2 || s_hour <= 3) &&
           (s_minten <= 5) && (s_min <= 9);
      chk("bcd_valid", 32'(ok), 32'(1));
      if (sec_tick) ticks_seen++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press_btn(input int idx, input int n);
    for (int k = 0; k < n; k++) begin
      if (idx == 0) btn_hour = 1'b1; else btn_min = 1'b1;
      tick(7);
      btn_hour = 1'b0;
      btn_min  = 1'b0;
      tick(10);
    end
  endtask

  initial begin
    int lat, gap, n, t0;
    bit found;
    rst = 1'b1; run_en = 1'b0; btn_hour = 1'b0; btn_min = 1'b0;
    tick(3);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_tick", 32'(sec_tick), 32'h0);
    chk("rst_colon", 32'(colon), 32'h0);

    // Free run: 600 cycles is one minute
    rst = 1'b0; run_en = 1'b1;
    t0 = ticks_seen;
    tick(599);
    chk("run_pre600", 32'(digits), 32'h0000);
    tick(1);
    chk("run_at600", 32'(digits), 32'h0001);
    chk("run_ticks", 32'(ticks_seen - t0), 32'd60);

    // Bouncy minute press
    for (int i = 0; i < 8; i++) begin
      btn_min = (i % 2 == 0);
      tick(1);
    end
    btn_min = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (lat < 0 && digits != 16'h0001) lat = i - 1;
    end
    chk("db_latency_ok", 32'(lat >= 6 && lat <= 8), 32'd1);
    chk("db_one_inc", 32'(digits), 32'h0002);
    btn_min = 1'b0;
    tick(12);
    chk("db_release", 32'(digits), 32'h0002);

    // Minute press restarts the second
    tick(50);
    btn_min = 1'b1;
    found = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (digits != 16'h0002) begin
        found = 1;
        break;
      end
    end
    chk("mp_seen", 32'(found), 32'd1);
    chk("mp_value", 32'(digits), 32'h0003);
    gap = -1;
    for (int j = 1; j <= 15; j++) begin
      tick(1);
      if (sec_tick) begin
        gap = j;
        break;
      end
    end
    chk("mp_next_tick", 32'(gap), 32'd10);
    btn_min = 1'b0;
    tick(10);

    // Frozen: presses still work, time does not advance
    run_en = 1'b0;
    t0 = ticks_seen;
    tick(50);
    chk("frz_digits", 32'(digits), 32'h0003);
    press_btn(1, 56);
    chk("frz_0059", 32'(digits), 32'h0059);
    press_btn(0, 1);
    chk("hp_0159", 32'(digits), 32'h0159);
    press_btn(0, 22);
    chk("hp_2359", 32'(digits), 32'h2359);
    chk("frz_ticks", 32'(ticks_seen - t0), 32'd0);

    // Midnight rollover
    run_en = 1'b1;
    n = 0;
    for (int i = 0; i < 700; i++) begin
      tick(1);
      if (sec_tick) begin
        n++;
        if (n == 59) chk("roll_pre", 32'(digits), 32'h2359);
        if (n == 60) break;
      end
    end
    chk("roll_wait", 32'(n), 32'd60);
    chk("roll_value", 32'(digits), 32'h0000);

    // Minute press lands on the 60th tick
    tick(593);
    btn_min = 1'b1;
    tick(7);
    chk("col_min", 32'(digits), 32'h0001);
    chk("col_min_tick", 32'(sec_tick), 32'd1);
    btn_min = 1'b0;
    tick(10);

    // Hour press lands on the 00:59 -> 01:00 carry
    run_en = 1'b0;
    press_btn(1, 58);
    chk("col_pre", 32'(digits), 32'h0059);
    run_en = 1'b1;
    tick(593);
    btn_hour = 1'b1;
    tick(7);
    chk("col_hour", 32'(digits), 32'h0100);
    btn_hour = 1'b0;
    tick(10);

    // Reset while the hour button is held
    btn_hour = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(2);
    chk("rst2_digits", 32'(digits), 32'h0);
    chk("rst2_tick", 32'(sec_tick), 32'h0);
    chk("rst2_colon", 32'(colon), 32'h0);
    rst = 1'b0;
    tick(3);
    chk("rst2_noinc", 32'(digits), 32'h0000);
    tick(12);
    chk("rst2_requal", 32'(digits), 32'h0100);
    btn_hour = 1'b0;
    tick(12);
    chk("rst2_release", 32'(digits), 32'h0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
